// File: rtl/bcd_calc_core_pkg.sv
// Shared definitions for the BCD add/subtract core: FSM states, operation codes, digit constants.
package bcd_calc_core_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NEGC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic logic [BCD_W-1:0] nines(input logic [BCD_W-1:0] d);
    return BCD_W'(BCD_MAX) - d;
  endfunction

endpackage

// File: rtl/bcd_calc_core_digit_adder.sv
// Single BCD digit adder: binary sum with +6 correction when the sum exceeds 9.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin_sum;

  assign bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout    = (bin_sum > 5'd9);
  assign s       = cout ? (bin_sum[3:0] + 4'd6) : bin_sum[3:0];

endmodule

// File: rtl/bcd_calc_core.sv
// Digit-serial BCD add/subtract core with edge-detected button loads/starts and a registered result.
module bcd_calc_core
  import bcd_calc_core_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   inA,
  input  logic [4*DIGITS-1:0]   inB,
  input  logic                  btnLoadA,
  input  logic                  btnLoadB,
  input  logic                  btnAdd,
  input  logic                  btnSub,
  output logic [4*DIGITS-1:0]   result,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     reg_a_q, reg_a_d;
  logic [W-1:0]     reg_b_q, reg_b_d;
  logic [W-1:0]     result_q, result_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [3:0]       btn_q;
  logic [3:0]       btn_edge;

  logic [BCD_W-1:0] dig_a, dig_b, dig_acc;
  logic [BCD_W-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;

  function automatic logic all_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Bit order: {sub, add, loadB, loadA}.
  assign btn_edge = {btnSub, btnAdd, btnLoadB, btnLoadA} & ~btn_q;

  assign dig_a   = reg_a_q[idx_q*BCD_W +: BCD_W];
  assign dig_b   = reg_b_q[idx_q*BCD_W +: BCD_W];
  assign dig_acc = acc_q[idx_q*BCD_W +: BCD_W];

  // NEGC turns the 9's-complement difference into its 10's complement magnitude.
  always_comb begin
    add_cin = cy_q;
    if (state_q == ST_NEGC) begin
      add_a = '0;
      add_b = nines(dig_acc);
    end else begin
      add_a = dig_a;
      add_b = (op_q == OP_SUB) ? nines(dig_b) : dig_b;
    end
  end

  bcd_digit_adder u_digit_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    idx_d    = idx_q;
    cy_d     = cy_q;
    acc_d    = acc_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (btn_edge[0] || btn_edge[1]) begin
          err_d = 1'b0;
          if (btn_edge[0]) begin
            if (all_bcd(inA)) reg_a_d = inA;
            else              err_d   = 1'b1;
          end
          if (btn_edge[1]) begin
            if (all_bcd(inB)) reg_b_d = inB;
            else              err_d   = 1'b1;
          end
        end else if (btn_edge[2] || btn_edge[3]) begin
          op_d    = btn_edge[2] ? OP_ADD : OP_SUB;
          cy_d    = !btn_edge[2];
          idx_d   = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d[idx_q*BCD_W +: BCD_W] = add_s;
        cy_d  = add_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (op_q == OP_ADD || add_cout) begin
            result_d = acc_d;
            neg_d    = 1'b0;
            ovf_d    = (op_q == OP_ADD) && add_cout;
            state_d  = ST_DONE;
          end else begin
            cy_d    = 1'b1;
            state_d = ST_NEGC;
          end
        end
      end

      ST_NEGC: begin
        acc_d[idx_q*BCD_W +: BCD_W] = add_s;
        cy_d  = add_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          result_d = acc_d;
          neg_d    = 1'b1;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      acc_q    <= '0;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      btn_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      cy_q     <= cy_d;
      acc_q    <= acc_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      btn_q    <= {btnSub, btnAdd, btnLoadB, btnLoadA};
    end
  end

  assign result = result_q;
  assign neg    = neg_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign busy   = (state_q == ST_CALC) || (state_q == ST_NEGC);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_calc_core.sv
// Directed self-checking bench for bcd_calc_core (DIGITS=2 main instance, DIGITS=4 wrap case).
module tb_bcd_calc_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inA, inB;
  logic        btnLoadA, btnLoadB, btnAdd, btnSub;
  logic [7:0]  result;
  logic        neg, ovf, busy, done, err;

  logic [15:0] inA4, inB4;
  logic        btnLoadA4, btnLoadB4, btnAdd4, btnSub4;
  logic [15:0] result4;
  logic        neg4, ovf4, busy4, done4, err4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_calc_core #(.DIGITS(2)) dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB),
    .btnLoadA(btnLoadA), .btnLoadB(btnLoadB), .btnAdd(btnAdd), .btnSub(btnSub),
    .result(result), .neg(neg), .ovf(ovf), .busy(busy), .done(done), .err(err)
  );

  bcd_calc_core #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .inA(inA4), .inB(inB4),
    .btnLoadA(btnLoadA4), .btnLoadB(btnLoadB4), .btnAdd(btnAdd4), .btnSub(btnSub4),
    .result(result4), .neg(neg4), .ovf(ovf4), .busy(busy4), .done(done4), .err(err4)
  );

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b, input bit do_a, input bit do_b);
    @(negedge clk);
    inA = a; inB = b; btnLoadA = do_a; btnLoadB = do_b;
    @(negedge clk);
    btnLoadA = 1'b0; btnLoadB = 1'b0;
  endtask

  // Press add/sub, then count negedges after the sampling edge until done appears.
  task automatic run_op(input string name, input bit do_add, input bit do_sub, input int exp_lat,
                        input logic [7:0] exp_res, input logic exp_neg, input logic exp_ovf);
    int lat;
    lat = 0;
    @(negedge clk);
    btnAdd = do_add; btnSub = do_sub;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      btnAdd = 1'b0; btnSub = 1'b0;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", name, busy); end
      end
      if (done === 1'b1) lat = n;
    end
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++;
    if (result !== exp_res) begin errors++; $display("FAIL %s_result: got %h expected %h", name, result, exp_res); end
    checks++;
    if (neg !== exp_neg || ovf !== exp_ovf || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: got neg=%b ovf=%b busy=%b expected neg=%b ovf=%b busy=0", name, neg, ovf, busy, exp_neg, exp_ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b expected 0", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inA = '0; inB = '0; btnLoadA = 0; btnLoadB = 0; btnAdd = 0; btnSub = 0;
    inA4 = '0; inB4 = '0; btnLoadA4 = 0; btnLoadB4 = 0; btnAdd4 = 0; btnSub4 = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== 8'h00 || result4 !== 16'h0000) begin
      errors++; $display("FAIL reset_result: got %h/%h expected 00/0000", result, result4);
    end
    checks++;
    if ({neg, ovf, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {neg, ovf, busy, done, err});
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    load_ab(8'h47, 8'h38, 1, 1);
    run_op("add_47_38", 1, 0, 3, 8'h85, 0, 0);
    load_ab(8'h99, 8'h01, 1, 1);
    run_op("add_99_01", 1, 0, 3, 8'h00, 0, 1);
  endtask

  task automatic test_sub();
    load_ab(8'h52, 8'h17, 1, 1);
    run_op("sub_52_17", 0, 1, 3, 8'h35, 0, 0);
    load_ab(8'h17, 8'h52, 1, 1);
    run_op("sub_17_52", 0, 1, 5, 8'h35, 1, 0);
    load_ab(8'h52, 8'h52, 1, 1);
    run_op("sub_equal", 0, 1, 3, 8'h00, 0, 0);
  endtask

  task automatic test_err();
    load_ab(8'h52, 8'h17, 1, 1);
    load_ab(8'h3A, 8'h17, 1, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    run_op("err_a_kept", 1, 0, 3, 8'h69, 0, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    load_ab(8'h12, 8'h00, 1, 0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
  endtask

  task automatic test_busy_discard();
    int dones;
    dones = 0;
    load_ab(8'h12, 8'h17, 1, 1);
    @(negedge clk);
    btnAdd = 1'b1;
    @(negedge clk);
    btnAdd = 1'b0; inB = 8'h50; btnLoadB = 1'b1; btnSub = 1'b1;
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      btnLoadB = 1'b0; btnSub = 1'b0;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL busy_one_done: got %0d expected 1", dones); end
    checks++;
    if (result !== 8'h29) begin errors++; $display("FAIL busy_result: got %h expected 29", result); end
    run_op("busy_b_kept", 1, 0, 3, 8'h29, 0, 0);
  endtask

  task automatic test_both_start();
    load_ab(8'h52, 8'h00, 1, 0);
    run_op("add_wins", 1, 1, 3, 8'h69, 0, 0);
  endtask

  task automatic test_start_with_load();
    bit seen;
    seen = 0;
    @(negedge clk);
    inA = 8'h30; btnLoadA = 1'b1; btnAdd = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      btnLoadA = 1'b0; btnAdd = 1'b0;
      if (busy === 1'b1 || done === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL start_dropped: got %b expected 0", seen); end
    run_op("load_took", 1, 0, 3, 8'h47, 0, 0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    load_ab(8'hA0, 8'h00, 1, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rstmid_err_pre: got %b expected 1", err); end
    @(negedge clk);
    btnAdd = 1'b1;
    @(negedge clk);
    btnAdd = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (result !== 8'h00 || {neg, ovf, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL rstmid_async: got %h %b expected 00 00000", result, {neg, ovf, busy, done, err});
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
    load_ab(8'h00, 8'h01, 0, 1);
    run_op("rstmid_a_cleared", 1, 0, 3, 8'h01, 0, 0);
  endtask

  task automatic test_digits4();
    int lat;
    lat = 0;
    @(negedge clk);
    inA4 = 16'h9999; inB4 = 16'h0001; btnLoadA4 = 1'b1; btnLoadB4 = 1'b1;
    @(negedge clk);
    btnLoadA4 = 1'b0; btnLoadB4 = 1'b0;
    @(negedge clk);
    btnAdd4 = 1'b1;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge clk);
      btnAdd4 = 1'b0;
      if (done4 === 1'b1) lat = n;
    end
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL d4_latency: got %0d expected 5", lat); end
    checks++;
    if (result4 !== 16'h0000 || ovf4 !== 1'b1 || neg4 !== 1'b0) begin
      errors++; $display("FAIL d4_wrap: got %h ovf=%b neg=%b expected 0000 ovf=1 neg=0", result4, ovf4, neg4);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_err();
    test_busy_discard();
    test_both_start();
    test_start_with_load();
    test_reset_mid();
    test_digits4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
